// File: rtl/hamming_best_match.sv
// hamming_best_match: tracks best/second-best Hamming distance per src group and emits a match record with threshold and ratio-test verdicts
module hamming_best_match #(
  parameter int DIST_W    = 9,
  parameter int IDX_W     = 10,
  parameter int MAX_DIST  = 64,
  parameter int RATIO_NUM = 4,
  parameter int RATIO_DEN = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic [DIST_W-1:0] i_dist,
  input  logic [IDX_W-1:0]  i_dst_idx,
  input  logic [IDX_W-1:0]  i_src_idx,
  input  logic              i_last,
  output logic              o_valid,
  output logic [IDX_W-1:0]  o_src_idx,
  output logic [IDX_W-1:0]  o_dst_idx,
  output logic [DIST_W-1:0] o_best_dist,
  output logic [DIST_W-1:0] o_second_dist,
  output logic [IDX_W:0]    o_cand_cnt,
  output logic              o_match
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACC  = 1'b1;
  localparam int PW = DIST_W + 3;
  localparam logic [DIST_W-1:0] MAXD = DIST_W'(MAX_DIST);
  logic [0:0]        st;
  logic [DIST_W-1:0] best, second, nb, ns;
  logic [IDX_W-1:0]  bidx, src, nbi, nsrc;
  logic [IDX_W:0]    cnt, nc;
  logic [PW-1:0]     pb, ps;
  logic              take, first, lt_b, pass;
  // next-state values include the current beat so the record can be built from them directly
  always_comb begin
    take  = i_valid && !i_flush;
    first = st == IDLE;
    lt_b  = i_dist < best;
    nb    = (first || lt_b) ? i_dist : best;
    nbi   = (first || lt_b) ? i_dst_idx : bidx;
    ns    = first ? '1 : lt_b ? best : (i_dist < second) ? i_dist : second;
    nc    = first ? (IDX_W+1)'(1) : &cnt ? cnt : cnt + 1'b1;
    nsrc  = first ? i_src_idx : src;
    pb    = {3'b000, nb} * PW'(RATIO_DEN);
    ps    = {3'b000, ns} * PW'(RATIO_NUM);
    pass  = (nb <= MAXD) && (pb < ps);
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st            <= IDLE;
      best          <= '0;
      second        <= '0;
      bidx          <= '0;
      src           <= '0;
      cnt           <= '0;
      o_valid       <= 1'b0;
      o_src_idx     <= '0;
      o_dst_idx     <= '0;
      o_best_dist   <= '0;
      o_second_dist <= '0;
      o_cand_cnt    <= '0;
      o_match       <= 1'b0;
    end else begin
      o_valid <= take && i_last;
      if (i_flush) st <= IDLE;
      else if (i_valid) begin
        st     <= i_last ? IDLE : ACC;
        best   <= nb;
        second <= ns;
        bidx   <= nbi;
        src    <= nsrc;
        cnt    <= nc;
      end
      if (take && i_last) begin
        o_src_idx     <= nsrc;
        o_dst_idx     <= nbi;
        o_best_dist   <= nb;
        o_second_dist <= ns;
        o_cand_cnt    <= nc;
        o_match       <= pass;
      end
    end
  end
endmodule
